// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared mode encoding, strap codes, CCTL windows and OSS bank decode
package cart_pkg;

  typedef enum logic [2:0] {
    M_INIT,
    M_SDX,
    M_OSS043,
    M_OSS034,
    M_CAR16,
    M_XEGS,
    M_OFF
  } mode_e;

  localparam logic [2:0] CFG_CAR16  = 3'b000;
  localparam logic [2:0] CFG_OSS034 = 3'b001;
  localparam logic [2:0] CFG_OSS043 = 3'b010;
  localparam logic [2:0] CFG_SDX    = 3'b011;
  localparam logic [2:0] CFG_XEGS   = 3'b100;

  localparam logic [2:0] SDX_WIN      = 3'b111;
  localparam logic [7:0] XEGS_RB_ADDR = 8'hFF;

  // 043M and 034M differ only in which of banks 1/2 the two middle codes pick
  function automatic logic [1:0] oss_bank_dec(input logic is_043, input logic [3:0] a);
    logic [1:0] bank;
    if (a == 4'b0000) bank = 2'd0;
    else if (!a[3] && a[1:0] == 2'b11) bank = is_043 ? 2'd2 : 2'd1;
    else if (a == 4'b0100) bank = is_043 ? 2'd1 : 2'd2;
    else bank = 2'd3;
    return bank;
  endfunction

endpackage

// File: rtl/cart_addr_map.sv
// rtl/cart_addr_map.sv - combinational cartridge window to ROM address translation
module cart_addr_map
  import cart_pkg::*;
#(
  parameter int          ROM_AW      = 19,
  parameter int          SDX_BANK_W  = 4,
  parameter int          XEGS_BANK_W = 4,
  parameter int unsigned SDX_BASE    = 'h00000,
  parameter int unsigned OSS043_BASE = 'h20000,
  parameter int unsigned OSS034_BASE = 'h24000,
  parameter int unsigned CAR_BASE    = 'h28000,
  parameter int unsigned XEGS_BASE   = 'h40000
) (
  input  mode_e                  mode,
  input  logic                   rd4,
  input  logic                   rd5,
  input  logic                   s4_n,
  input  logic                   s5_n,
  input  logic [12:0]            cart_a,
  input  logic [SDX_BANK_W-1:0]  sdx_bank,
  input  logic [1:0]             oss_bank,
  input  logic [XEGS_BANK_W-1:0] xegs_bank,
  output logic [ROM_AW-1:0]      rom_a,
  output logic                   rom_sel
);

  logic sel4;
  logic sel5;
  logic [1:0] oss_sel;

  // both selects low is an illegal bus state and must not enable the ROM
  assign sel4    = rd4 & ~s4_n & s5_n;
  assign sel5    = rd5 & ~s5_n & s4_n;
  assign rom_sel = sel4 | sel5;
  assign oss_sel = cart_a[12] ? 2'b11 : oss_bank;

  always_comb begin
    rom_a = '0;
    if (rom_sel) begin
      case (mode)
        M_SDX: begin
          if (rd4)
            rom_a = sel4 ? ROM_AW'(CAR_BASE) + ROM_AW'(cart_a)
                         : ROM_AW'(CAR_BASE + 32'h2000) + ROM_AW'(cart_a);
          else
            rom_a = ROM_AW'(SDX_BASE) + ROM_AW'({sdx_bank, cart_a});
        end
        M_CAR16:
          rom_a = sel4 ? ROM_AW'(CAR_BASE) + ROM_AW'(cart_a)
                       : ROM_AW'(CAR_BASE + 32'h2000) + ROM_AW'(cart_a);
        M_OSS043: rom_a = ROM_AW'(OSS043_BASE) + ROM_AW'({oss_sel, cart_a[11:0]});
        M_OSS034: rom_a = ROM_AW'(OSS034_BASE) + ROM_AW'({oss_sel, cart_a[11:0]});
        M_XEGS:
          rom_a = sel4 ? ROM_AW'(XEGS_BASE) + ROM_AW'({xegs_bank, cart_a})
                       : ROM_AW'(XEGS_BASE) + ROM_AW'({{XEGS_BANK_W{1'b1}}, cart_a});
        default: rom_a = '0;
      endcase
    end
  end

endmodule

// File: rtl/cart_bank_ctrl.sv
// rtl/cart_bank_ctrl.sv - multi-personality cartridge banking: mode FSM, bank registers, bus outputs
module cart_bank_ctrl
  import cart_pkg::*;
#(
  parameter int          ROM_AW      = 19,
  parameter int          CFG_W       = 3,
  parameter int          SDX_BANK_W  = 4,
  parameter int          XEGS_BANK_W = 4,
  parameter int unsigned SDX_BASE    = 'h00000,
  parameter int unsigned OSS043_BASE = 'h20000,
  parameter int unsigned OSS034_BASE = 'h24000,
  parameter int unsigned CAR_BASE    = 'h28000,
  parameter int unsigned XEGS_BASE   = 'h40000
) (
  input  logic              phi2,
  input  logic              reset,
  input  logic [CFG_W-1:0]  cfg,
  input  logic [12:0]       cart_a,
  input  logic [7:0]        cart_d_in,
  input  logic              s4_n,
  input  logic              s5_n,
  input  logic              cctl_n,
  input  logic              r_w,
  input  logic [7:0]        rom_d_in,
  output logic              rd4,
  output logic              rd5,
  output logic [ROM_AW-1:0] rom_a,
  output logic              rom_ce_n,
  output logic              rom_oe_n,
  output logic [7:0]        cart_d_out,
  output logic              cart_d_oe,
  output logic              led_sdx,
  output logic              led_car
);

  mode_e                  mode_q, mode_d;
  logic                   rd4_q, rd4_d, rd5_q, rd5_d;
  logic [SDX_BANK_W-1:0]  sdx_bank_q, sdx_bank_d;
  logic [1:0]             oss_bank_q, oss_bank_d;
  logic [XEGS_BANK_W-1:0] xegs_bank_q, xegs_bank_d;
  logic                   cctl_wr, rb_hit, rom_sel;
  logic [7:0]             rb_data;
  logic                   unused_d;

  assign cctl_wr  = ~cctl_n & ~r_w;
  assign unused_d = ^cart_d_in;

  always_ff @(posedge phi2) begin
    if (reset) begin
      mode_q      <= M_INIT;
      rd4_q       <= 1'b0;
      rd5_q       <= 1'b0;
      sdx_bank_q  <= '1;
      oss_bank_q  <= '0;
      xegs_bank_q <= '0;
    end else begin
      mode_q      <= mode_d;
      rd4_q       <= rd4_d;
      rd5_q       <= rd5_d;
      sdx_bank_q  <= sdx_bank_d;
      oss_bank_q  <= oss_bank_d;
      xegs_bank_q <= xegs_bank_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    rd4_d       = rd4_q;
    rd5_d       = rd5_q;
    sdx_bank_d  = sdx_bank_q;
    oss_bank_d  = oss_bank_q;
    xegs_bank_d = xegs_bank_q;
    case (mode_q)
      M_INIT: begin
        if (cfg == CFG_W'(CFG_CAR16)) begin
          mode_d = M_CAR16; rd4_d = 1'b1; rd5_d = 1'b1;
        end else if (cfg == CFG_W'(CFG_OSS034)) begin
          mode_d = M_OSS034; rd5_d = 1'b1;
        end else if (cfg == CFG_W'(CFG_OSS043)) begin
          mode_d = M_OSS043; rd5_d = 1'b1;
        end else if (cfg == CFG_W'(CFG_SDX)) begin
          mode_d = M_SDX; rd5_d = 1'b1;
        end else if (cfg == CFG_W'(CFG_XEGS)) begin
          mode_d = M_XEGS; rd4_d = 1'b1; rd5_d = 1'b1;
        end else begin
          mode_d = M_OFF;
        end
      end
      // SDX window stays live even when everything is switched off
      M_SDX: begin
        if (cctl_wr && cart_a[7:5] == SDX_WIN) begin
          if (!cart_a[3]) begin
            rd4_d      = 1'b0;
            rd5_d      = 1'b1;
            sdx_bank_d = SDX_BANK_W'({~cart_a[4], ~cart_a[2:0]});
          end else if (!cart_a[2]) begin
            rd4_d = 1'b1;
            rd5_d = 1'b1;
          end else begin
            rd4_d = 1'b0;
            rd5_d = 1'b0;
          end
        end
      end
      // rd5 low in OSS mode means permanently disabled until reset
      M_OSS043, M_OSS034: begin
        if (cctl_wr && rd5_q) begin
          if (cart_a[3]) rd5_d = 1'b0;
          else oss_bank_d = oss_bank_dec(mode_q == M_OSS043, cart_a[3:0]);
        end
      end
      M_XEGS: begin
        if (cctl_wr && cart_a[7:0] != XEGS_RB_ADDR) begin
          xegs_bank_d = cart_d_in[XEGS_BANK_W-1:0];
          rd4_d       = ~cart_d_in[7];
          rd5_d       = ~cart_d_in[7];
        end
      end
      default: ;
    endcase
  end

  cart_addr_map #(
    .ROM_AW     (ROM_AW),
    .SDX_BANK_W (SDX_BANK_W),
    .XEGS_BANK_W(XEGS_BANK_W),
    .SDX_BASE   (SDX_BASE),
    .OSS043_BASE(OSS043_BASE),
    .OSS034_BASE(OSS034_BASE),
    .CAR_BASE   (CAR_BASE),
    .XEGS_BASE  (XEGS_BASE)
  ) u_map (
    .mode     (mode_q),
    .rd4      (rd4_q),
    .rd5      (rd5_q),
    .s4_n     (s4_n),
    .s5_n     (s5_n),
    .cart_a   (cart_a),
    .sdx_bank (sdx_bank_q),
    .oss_bank (oss_bank_q),
    .xegs_bank(xegs_bank_q),
    .rom_a    (rom_a),
    .rom_sel  (rom_sel)
  );

  always_comb begin
    rb_data    = 8'(xegs_bank_q);
    rb_data[7] = ~rd5_q;
  end

  assign rb_hit     = (mode_q == M_XEGS) & ~cctl_n & r_w & (cart_a[7:0] == XEGS_RB_ADDR);
  assign rd4        = rd4_q;
  assign rd5        = rd5_q;
  assign rom_ce_n   = ~rom_sel;
  assign rom_oe_n   = ~rom_sel | ~r_w;
  assign cart_d_oe  = (phi2 & r_w & rom_sel) | rb_hit;
  assign cart_d_out = rb_hit ? rb_data : rom_d_in;
  assign led_sdx    = ~((mode_q == M_SDX) & rd5_q & ~rd4_q);
  assign led_car    = ~((mode_q == M_CAR16) | ((mode_q == M_SDX) & rd4_q) |
                        ((mode_q == M_XEGS) & rd5_q));

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// tb/tb_cart_bank_ctrl.sv - scoreboard bench for cart_bank_ctrl personalities
module tb_cart_bank_ctrl;

  localparam logic [7:0] ROM_D = 8'h5A;

  logic        phi2 = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  cfg = 3'b111;
  logic [12:0] cart_a = '0;
  logic [7:0]  cart_d_in = '0;
  logic        s4_n = 1'b1, s5_n = 1'b1, cctl_n = 1'b1, r_w = 1'b1;
  logic [7:0]  rom_d_in = ROM_D;
  logic        rd4, rd5, rom_ce_n, rom_oe_n, cart_d_oe, led_sdx, led_car;
  logic [18:0] rom_a;
  logic [7:0]  cart_d_out;

  cart_bank_ctrl dut (
    .phi2(phi2), .reset(reset), .cfg(cfg), .cart_a(cart_a), .cart_d_in(cart_d_in),
    .s4_n(s4_n), .s5_n(s5_n), .cctl_n(cctl_n), .r_w(r_w), .rom_d_in(rom_d_in),
    .rd4(rd4), .rd5(rd5), .rom_a(rom_a), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
    .cart_d_out(cart_d_out), .cart_d_oe(cart_d_oe), .led_sdx(led_sdx), .led_car(led_car)
  );

  always #5 phi2 = ~phi2;

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  cfg;
    logic [12:0] a;
    logic        s4n, s5n, cctln, rw;
    logic [7:0]  d;
    logic        e4, e5;
    logic [18:0] ra;
    logic        hit;
    logic [7:0]  rbv;
    logic [1:0]  leds;
  } step_t;

  typedef struct {
    string       name;
    logic [33:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic       cur_rst = 1'b1;
  logic [2:0] cur_cfg = 3'b111;

  function automatic step_t S(string n, logic [12:0] a, logic s4n, logic s5n, logic cctln,
                              logic rw, logic [7:0] d, logic e4, logic e5, logic [18:0] ra,
                              logic hit, logic [7:0] rbv, logic [1:0] leds);
    step_t s;
    s.name = n; s.rst = cur_rst; s.cfg = cur_cfg; s.a = a; s.s4n = s4n; s.s5n = s5n;
    s.cctln = cctln; s.rw = rw; s.d = d; s.e4 = e4; s.e5 = e5; s.ra = ra; s.hit = hit;
    s.rbv = rbv; s.leds = leds;
    return s;
  endfunction

  function automatic step_t I(string n, logic e4, logic e5, logic [1:0] leds);
    return S(n, 13'h0, 1, 1, 1, 1, 8'h00, e4, e5, 19'h0, 0, 8'h00, leds);
  endfunction

  function automatic step_t W(string n, logic [7:0] a8, logic [7:0] d, logic e4, logic e5,
                              logic [1:0] leds);
    return S(n, {5'h0, a8}, 1, 1, 0, 0, d, e4, e5, 19'h0, 0, 8'h00, leds);
  endfunction

  function automatic step_t R(string n, logic [12:0] a, logic s4n, logic s5n, logic rw,
                              logic e4, logic e5, logic [18:0] ra, logic [1:0] leds);
    return S(n, a, s4n, s5n, 1, rw, 8'h00, e4, e5, ra, 0, 8'h00, leds);
  endfunction

  function automatic step_t B(string n, logic e4, logic e5, logic hit, logic [7:0] rbv,
                              logic [1:0] leds);
    return S(n, 13'h0FF, 1, 1, 0, 1, 8'h00, e4, e5, 19'h0, hit, rbv, leds);
  endfunction

  // expected bus picture for one step, sampled while phi2 is high
  function automatic logic [33:0] model(step_t s);
    logic sel, ce_n, oe_n, doe;
    logic [7:0] dout;
    sel  = (s.e4 & ~s.s4n & s.s5n) | (s.e5 & ~s.s5n & s.s4n);
    ce_n = ~sel;
    oe_n = ce_n | ~s.rw;
    doe  = (s.rw & sel) | s.hit;
    dout = s.hit ? s.rbv : ROM_D;
    return {s.e4, s.e5, ce_n, oe_n, doe, (sel ? s.ra : 19'h0), dout, s.leds};
  endfunction

  function automatic logic [33:0] observe();
    return {rd4, rd5, rom_ce_n, rom_oe_n, cart_d_oe, rom_a, cart_d_out, led_sdx, led_car};
  endfunction

  task automatic drive_step(input step_t s);
    exp_t e;
    @(negedge phi2);
    reset = s.rst; cfg = s.cfg; cart_a = s.a; s4_n = s.s4n; s5_n = s.s5n;
    cctl_n = s.cctln; r_w = s.rw; cart_d_in = s.d;
    e.name = s.name;
    e.v = model(s);
    sb.push_back(e);
    @(posedge phi2);
    #2;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    cur_rst = 1; cur_cfg = 3'b011;
    st.push_back(I("reset_state", 0, 0, 2'b11));
    st.push_back(R("reset_rom_a", 13'h0123, 1, 0, 1, 0, 0, 19'h0, 2'b11));
    st.push_back(W("reset_wins_cctl", 8'hE2, 8'h00, 0, 0, 2'b11));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, observe(), e.v);
      end
    end
  endtask

  task automatic test_sdx();
    step_t st[$];
    exp_t  e;
    cur_rst = 1; cur_cfg = 3'b011;
    st.push_back(I("sdx_rst", 0, 0, 2'b11));
    cur_rst = 0;
    st.push_back(I("sdx_init", 0, 1, 2'b01));
    cur_cfg = 3'b111;
    st.push_back(R("sdx_bank_f", 13'h0123, 1, 0, 1, 0, 1, 19'h1E123, 2'b01));
    st.push_back(W("sdx_wr_e2", 8'hE2, 8'h00, 0, 1, 2'b01));
    st.push_back(R("sdx_bank_d", 13'h0123, 1, 0, 1, 0, 1, 19'h1A123, 2'b01));
    st.push_back(W("sdx_wr_e8_car", 8'hE8, 8'h00, 1, 1, 2'b10));
    st.push_back(R("sdx_car_8000", 13'h0040, 0, 1, 1, 1, 1, 19'h28040, 2'b10));
    st.push_back(R("sdx_car_a000", 13'h0040, 1, 0, 1, 1, 1, 19'h2A040, 2'b10));
    st.push_back(W("sdx_wr_ec_off", 8'hEC, 8'h00, 0, 0, 2'b11));
    st.push_back(R("sdx_off_rd", 13'h0123, 1, 0, 1, 0, 0, 19'h0, 2'b11));
    st.push_back(W("sdx_wr_e0_reen", 8'hE0, 8'h00, 0, 1, 2'b01));
    st.push_back(R("sdx_reen_bank", 13'h0123, 1, 0, 1, 0, 1, 19'h1E123, 2'b01));
    st.push_back(W("sdx_wr_outside", 8'hD0, 8'h00, 0, 1, 2'b01));
    st.push_back(R("sdx_outside_kept", 13'h0123, 1, 0, 1, 0, 1, 19'h1E123, 2'b01));
    st.push_back(R("sdx_illegal_sel", 13'h0123, 0, 0, 1, 0, 1, 19'h0, 2'b01));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, observe(), e.v);
      end
    end
  endtask

  task automatic test_oss();
    step_t st[$];
    exp_t  e;
    cur_rst = 1; cur_cfg = 3'b010;
    st.push_back(I("o43_rst", 0, 0, 2'b11));
    cur_rst = 0;
    st.push_back(I("o43_init", 0, 1, 2'b11));
    st.push_back(R("o43_bank0", 13'h0010, 1, 0, 1, 0, 1, 19'h20010, 2'b11));
    st.push_back(W("o43_wr_03", 8'h03, 8'h00, 0, 1, 2'b11));
    st.push_back(R("o43_bank2", 13'h0010, 1, 0, 1, 0, 1, 19'h22010, 2'b11));
    st.push_back(R("o43_b000_fixed", 13'h1010, 1, 0, 1, 0, 1, 19'h23010, 2'b11));
    st.push_back(W("o43_wr_04", 8'h04, 8'h00, 0, 1, 2'b11));
    st.push_back(R("o43_bank1", 13'h0010, 1, 0, 1, 0, 1, 19'h21010, 2'b11));
    st.push_back(W("o43_wr_08_dis", 8'h08, 8'h00, 0, 0, 2'b11));
    st.push_back(W("o43_wr_00_stays", 8'h00, 8'h00, 0, 0, 2'b11));
    st.push_back(R("o43_dis_rd", 13'h0010, 1, 0, 1, 0, 0, 19'h0, 2'b11));
    cur_rst = 1; cur_cfg = 3'b001;
    st.push_back(I("o34_rst", 0, 0, 2'b11));
    cur_rst = 0;
    st.push_back(I("o34_init", 0, 1, 2'b11));
    st.push_back(W("o34_wr_03", 8'h03, 8'h00, 0, 1, 2'b11));
    st.push_back(R("o34_bank1", 13'h0010, 1, 0, 1, 0, 1, 19'h25010, 2'b11));
    st.push_back(W("o34_wr_04", 8'h04, 8'h00, 0, 1, 2'b11));
    st.push_back(R("o34_bank2", 13'h0010, 1, 0, 1, 0, 1, 19'h26010, 2'b11));
    st.push_back(W("o34_wr_01", 8'h01, 8'h00, 0, 1, 2'b11));
    st.push_back(R("o34_bank3", 13'h0010, 1, 0, 1, 0, 1, 19'h27010, 2'b11));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, observe(), e.v);
      end
    end
  endtask

  task automatic test_car16();
    step_t st[$];
    exp_t  e;
    cur_rst = 1; cur_cfg = 3'b000;
    st.push_back(I("car_rst", 0, 0, 2'b11));
    cur_rst = 0;
    st.push_back(I("car_init", 1, 1, 2'b10));
    st.push_back(R("car_8000", 13'h0ABC, 0, 1, 1, 1, 1, 19'h28ABC, 2'b10));
    st.push_back(R("car_a000", 13'h0ABC, 1, 0, 1, 1, 1, 19'h2AABC, 2'b10));
    st.push_back(W("car_cctl_ignored", 8'hEC, 8'h80, 1, 1, 2'b10));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, observe(), e.v);
      end
    end
  endtask

  task automatic test_xegs();
    step_t st[$];
    exp_t  e;
    cur_rst = 1; cur_cfg = 3'b100;
    st.push_back(I("xg_rst", 0, 0, 2'b11));
    cur_rst = 0;
    st.push_back(I("xg_init", 1, 1, 2'b10));
    st.push_back(R("xg_bank0", 13'h0000, 0, 1, 1, 1, 1, 19'h40000, 2'b10));
    st.push_back(W("xg_wr_05", 8'h00, 8'h05, 1, 1, 2'b10));
    st.push_back(R("xg_8000_bank5", 13'h0000, 0, 1, 1, 1, 1, 19'h4A000, 2'b10));
    st.push_back(R("xg_a000_last", 13'h0000, 1, 0, 1, 1, 1, 19'h5E000, 2'b10));
    st.push_back(B("xg_readback_05", 1, 1, 1, 8'h05, 2'b10));
    st.push_back(W("xg_wr_d5ff_ign", 8'hFF, 8'h03, 1, 1, 2'b10));
    st.push_back(R("xg_d5ff_kept", 13'h0001, 0, 1, 1, 1, 1, 19'h4A001, 2'b10));
    st.push_back(W("xg_wr_85_off", 8'h10, 8'h85, 0, 0, 2'b11));
    st.push_back(B("xg_readback_85", 0, 0, 1, 8'h85, 2'b11));
    st.push_back(R("xg_off_rd", 13'h0000, 0, 1, 1, 0, 0, 19'h0, 2'b11));
    st.push_back(W("xg_wr_1c_reen", 8'h00, 8'h1C, 1, 1, 2'b10));
    st.push_back(R("xg_bank_c_wrap", 13'h0100, 0, 1, 1, 1, 1, 19'h58100, 2'b10));
    st.push_back(R("xg_rom_write_cyc", 13'h0100, 0, 1, 0, 1, 1, 19'h58100, 2'b10));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, observe(), e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  e;
    cur_rst = 1; cur_cfg = 3'b100;
    st.push_back(W("b2b_rst_with_wr", 8'h00, 8'h07, 0, 0, 2'b11));
    cur_rst = 0;
    st.push_back(I("b2b_resample", 1, 1, 2'b10));
    st.push_back(B("b2b_bank_cleared", 1, 1, 1, 8'h00, 2'b10));
    st.push_back(R("b2b_8000_bank0", 13'h0000, 0, 1, 1, 1, 1, 19'h40000, 2'b10));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, observe(), e.v);
      end
    end
  endtask

  task automatic test_off();
    step_t st[$];
    exp_t  e;
    cur_rst = 1; cur_cfg = 3'b111;
    st.push_back(I("off_rst", 0, 0, 2'b11));
    cur_rst = 0;
    st.push_back(I("off_init", 0, 0, 2'b11));
    st.push_back(W("off_wr_e0", 8'hE0, 8'h00, 0, 0, 2'b11));
    st.push_back(W("off_wr_00", 8'h00, 8'h01, 0, 0, 2'b11));
    st.push_back(B("off_no_readback", 0, 0, 0, 8'h00, 2'b11));
    st.push_back(R("off_s4", 13'h0010, 0, 1, 1, 0, 0, 19'h0, 2'b11));
    st.push_back(R("off_s5", 13'h0010, 1, 0, 1, 0, 0, 19'h0, 2'b11));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, observe(), e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sdx();
    test_oss();
    test_car16();
    test_xegs();
    test_back_to_back();
    test_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
